// File: rtl/dac_pkg.sv
// Shared encodings for the DAC bank scheduler: channel formats, AD5449 commands, FSM states.
// Latency: n/a (declarations and a pure formatting function only).
// Backpressure: n/a.
package dac_pkg;

    // Per-channel frame format selectors (2 bits per channel in FMT_SEL)
    localparam logic [1:0] FMT_DAC7311  = 2'd0;
    localparam logic [1:0] FMT_AD5449_A = 2'd1;
    localparam logic [1:0] FMT_AD5449_B = 2'd2;

    // AD5449 command nibbles: load-and-update DAC A / DAC B
    localparam logic [3:0] AD5449_CMD_A = 4'b0001;
    localparam logic [3:0] AD5449_CMD_B = 4'b0100;

    // Bus address nibble that selects a DAC write
    localparam logic [3:0] ADDR_NIB_DEFAULT = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic logic is_ad5449(input logic [1:0] fmt);
        return (fmt == FMT_AD5449_A) || (fmt == FMT_AD5449_B);
    endfunction

    // Builds the 16-bit serial word from a left-justified 12-bit code
    function automatic logic [15:0] format_word(input logic [1:0] fmt, input logic [11:0] code);
        logic [15:0] word;
        case (fmt)
            FMT_AD5449_A: word = {AD5449_CMD_A, code};
            FMT_AD5449_B: word = {AD5449_CMD_B, code};
            default:      word = {2'b00, code, 2'b00};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/dac_frame_serializer.sv
// Shifts one FRAME_W frame out MSB first: sync, lead half-period, FRAME_W clock falls, tail half-period.
// Latency: sync active the cycle after start; done pulses 2*FRAME_W+1 half-periods later.
// Backpressure: start is ignored while a frame is in flight; the caller waits for done.
module dac_frame_serializer #(
    parameter int FRAME_W = 16,
    parameter int CLK_DIV = 2
) (
    input  logic               xclk,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               sclk,
    output logic               sdata,
    output logic               sync_active,
    output logic               done
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HP_W  = $clog2(2 * FRAME_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(2 * FRAME_W);

    logic               active;
    logic               sclk_r;
    logic [FRAME_W-1:0] shreg;
    logic [HP_W-1:0]    hp;     // half-period index: odd = clk low carrying bit hp/2
    logic [DIV_W-1:0]   div;

    // Half-period sequencer; data shifts only on the rising clk transition so it is stable at the fall
    always_ff @(posedge xclk) begin
        if (reset) begin
            active <= 1'b0;
            sclk_r <= 1'b1;
            shreg  <= '0;
            hp     <= '0;
            div    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (start) begin
                    active <= 1'b1;
                    shreg  <= frame;
                    hp     <= '0;
                    div    <= '0;
                    sclk_r <= 1'b1;
                end
            end else if (div == DIV_LAST) begin
                div <= '0;
                if (hp == HP_LAST) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    hp     <= hp + 1'b1;
                    sclk_r <= ~sclk_r;
                    if (hp[0]) shreg <= shreg << 1;
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    assign sclk        = sclk_r;
    assign sdata       = active & shreg[FRAME_W-1];
    assign sync_active = active;

endmodule

// File: rtl/dac_bank_scheduler.sv
// Per-channel shadow/pending buffer with round-robin scheduling onto a shared serial DAC bus; DAC_READBACK_EN adds a shadow readback port.
// Latency: bus write to sync active is 2 cycles when idle; readback data 1 cycle after the read strobe.
// Backpressure: none toward the bus; writes land every cycle and the last write per channel wins.
module dac_bank_scheduler
    import dac_pkg::*;
#(
    parameter int              NUM_CH     = 16,
    parameter int              DATA_W     = 12,
    parameter int              FRAME_W    = 16,
    parameter int              CLK_DIV    = 2,
    parameter logic [3:0]      ADDR_NIB   = ADDR_NIB_DEFAULT,
    parameter logic [2*NUM_CH-1:0] FMT_SEL = '0,
    parameter bit              INIT_ALL   = 1'b1,
    parameter bit              INVERT_OUT = 1'b1,
    parameter int              CLR_HOLD   = 8
) (
    input  logic              xclk,
    input  logic              reset,
    input  logic              write_qualified,
    input  logic [7:0]        ab,
    input  logic [DATA_W-1:0] db_in,
`ifdef DAC_READBACK_EN
    input  logic              read_qualified,
    output logic [DATA_W-1:0] db_out,
    output logic              data_avail,
`endif
    output logic              busy,
    output logic              dac_clk,
    output logic              dac_data,
    output logic [NUM_CH-1:0] dac_sync,
    output logic              dac_clr
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAP_W = $clog2(2 * CLK_DIV);
    localparam int CLR_W = (CLR_HOLD > 0) ? $clog2(CLR_HOLD + 1) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(2 * CLK_DIV - 1);
    localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(1) << (DATA_W - 1);

    // All AD5449 channels share the sync pin of the lowest-numbered one
    function automatic int first_ad(input logic [2*NUM_CH-1:0] sel);
        int idx;
        idx = 0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (is_ad5449(sel[2*i +: 2])) idx = i;
        return idx;
    endfunction
    localparam int AD_SYNC = first_ad(FMT_SEL);

    state_e             state, state_nxt;
    logic [DATA_W-1:0]  shadow [NUM_CH];
    logic [NUM_CH-1:0]  pending;
    logic [CH_W-1:0]    rr_ptr, cur_ch, sync_idx, sel;
    logic [GAP_W-1:0]   gap_cnt;
    logic [CLR_W-1:0]   clr_cnt;
    logic               start;
    logic [1:0]         sel_fmt;
    logic [15:0]        code_lj;
    logic [15:0]        word;
    logic [CH_W-1:0]    wr_ch;
    logic               wr_acc;
    logic               ser_clk, ser_data, ser_sync, ser_done;
    logic [NUM_CH-1:0]  sync_log;

    assign wr_ch  = ab[CH_W-1:0];
    assign wr_acc = write_qualified && (ab[7:4] == ADDR_NIB) && (int'(ab[3:0]) < NUM_CH);

    // Round-robin pick: first pending channel at or after rr_ptr, wrapping at NUM_CH
    always_comb begin
        automatic int j;
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (pending[j]) sel = CH_W'(j);
        end
    end

    // Frame for the picked channel; narrow codes are left-justified to 12 bits
    always_comb begin
        sel_fmt = FMT_SEL[2*int'(sel) +: 2];
        code_lj = 16'(shadow[sel]) << (16 - DATA_W);
        word    = format_word(sel_fmt, code_lj[15:4]);
    end

    // FSM state register
    always_ff @(posedge xclk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|pending) state_nxt = ST_SEND;
            ST_SEND: if (ser_done) state_nxt = ST_GAP;
            ST_GAP:  if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        start = (state == ST_IDLE) && (|pending);
        busy  = (state != ST_IDLE) || (|pending);
    end

    // Channel buffers, scheduling pointer, gap timer and clear-hold counter
    always_ff @(posedge xclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= MIDSCALE;
            pending  <= {NUM_CH{INIT_ALL}};
            rr_ptr   <= '0;
            cur_ch   <= '0;
            sync_idx <= '0;
            gap_cnt  <= '0;
            clr_cnt  <= CLR_W'(CLR_HOLD);
        end else begin
            if (clr_cnt != '0) clr_cnt <= clr_cnt - 1'b1;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
            if (start) begin
                cur_ch   <= sel;
                sync_idx <= is_ad5449(sel_fmt) ? CH_W'(AD_SYNC) : sel;
                pending[sel] <= 1'b0;
            end
            // A write in the same cycle as the clear keeps the channel pending
            if (wr_acc) begin
                shadow[wr_ch]  <= db_in;
                pending[wr_ch] <= 1'b1;
            end
            if (state == ST_GAP && gap_cnt == GAP_LAST)
                rr_ptr <= (int'(cur_ch) == NUM_CH - 1) ? '0 : cur_ch + 1'b1;
        end
    end

`ifdef DAC_READBACK_EN
    // Registered shadow readback; out-of-range channels read as zero
    always_ff @(posedge xclk) begin
        if (reset) begin
            db_out     <= '0;
            data_avail <= 1'b0;
        end else begin
            data_avail <= read_qualified && (ab[7:4] == ADDR_NIB);
            if (read_qualified && (ab[7:4] == ADDR_NIB))
                db_out <= (int'(ab[3:0]) < NUM_CH) ? shadow[wr_ch] : '0;
        end
    end
`endif

    dac_frame_serializer #(
        .FRAME_W (FRAME_W),
        .CLK_DIV (CLK_DIV)
    ) u_ser (
        .xclk        (xclk),
        .reset       (reset),
        .start       (start),
        .frame       (FRAME_W'(word)),
        .sclk        (ser_clk),
        .sdata       (ser_data),
        .sync_active (ser_sync),
        .done        (ser_done)
    );

    // Reset gates the pins combinationally so a frame aborts in the reset cycle itself
    always_comb begin
        sync_log = '0;
        if (ser_sync && !reset) sync_log = NUM_CH'(1) << sync_idx;
    end

    assign dac_sync = sync_log ^ {NUM_CH{INVERT_OUT}};
    assign dac_clk  = (ser_clk | reset) ^ INVERT_OUT;
    assign dac_data = (ser_data & ~reset) ^ INVERT_OUT;
    assign dac_clr  = (reset | (clr_cnt != '0)) ^ INVERT_OUT;

endmodule

// File: tb/tb_dac_bank_scheduler.sv
module tb_dac_bank_scheduler;
    logic        xclk = 1'b0;
    logic        reset = 1'b1;
    logic        write_qualified = 1'b0;
    logic [7:0]  ab = 8'h00;
    logic [11:0] db_in = 12'h000;
    logic        busy, dac_clk, dac_data, dac_clr;
    logic [15:0] dac_sync;
`ifdef DAC_READBACK_EN
    logic        read_qualified = 1'b0;
    logic [11:0] db_out;
    logic        data_avail;
`endif

    // ch14 = AD5449 A, ch15 = AD5449 B, rest DAC7311
    dac_bank_scheduler #(
        .NUM_CH(16), .DATA_W(12), .FRAME_W(16), .CLK_DIV(2), .ADDR_NIB(4'h4),
        .FMT_SEL(32'h9000_0000), .INIT_ALL(1'b1), .INVERT_OUT(1'b1), .CLR_HOLD(8)
    ) u_dut (
        .xclk(xclk), .reset(reset), .write_qualified(write_qualified), .ab(ab), .db_in(db_in),
`ifdef DAC_READBACK_EN
        .read_qualified(read_qualified), .db_out(db_out), .data_avail(data_avail),
`endif
        .busy(busy), .dac_clk(dac_clk), .dac_data(dac_data), .dac_sync(dac_sync), .dac_clr(dac_clr)
    );

    always #5 xclk = ~xclk;

    // Board inverters are in the path: logical levels are pin levels inverted
    wire [15:0] lsync = ~dac_sync;
    wire        lclk  = ~dac_clk;
    wire        ldata = ~dac_data;
    wire        lclr  = ~dac_clr;

    typedef struct { int idx; logic [15:0] frame; } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int frames_done = 0;
    int target = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Frame monitor: captures data on each logical clk fall while a sync is active
    logic        in_frame = 1'b0;
    logic        prev_clk = 1'b1;
    logic [15:0] mon_sync = '0;
    logic [15:0] mon_shift = '0;
    int          mon_bits = 0;

    always @(negedge xclk) begin
        if (reset) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (lsync != 16'h0) begin
                in_frame  = 1'b1;
                mon_sync  = lsync;
                mon_bits  = 0;
                mon_shift = '0;
            end
        end else if (lsync == 16'h0) begin
            in_frame = 1'b0;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got sync 0x%0h data 0x%0h, expected no frame", mon_sync, mon_shift);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_sync", 32'(mon_sync), 32'(16'(1) << e.idx));
                check("frame_len", 32'(mon_bits), 32'd16);
                check("frame_data", 32'(mon_shift), 32'(e.frame));
            end
            frames_done++;
        end else if (prev_clk && !lclk) begin
            mon_shift = {mon_shift[14:0], ldata};
            mon_bits++;
        end
        prev_clk = lclk;
    end

    task automatic expect_frame(input int idx, input logic [15:0] frame);
        exp_t e;
        e.idx = idx;
        e.frame = frame;
        exp_q.push_back(e);
        target++;
    endtask

    task automatic expect_init_frames();
        for (int i = 0; i < 14; i++) expect_frame(i, 16'h2000);
        expect_frame(14, 16'h1800);
        expect_frame(14, 16'h4800);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [11:0] val);
        @(posedge xclk); #1;
        write_qualified = 1'b1;
        ab = addr;
        db_in = val;
    endtask

    task automatic wr_end();
        @(posedge xclk); #1;
        write_qualified = 1'b0;
    endtask

    task automatic wait_frames();
        int n = 0;
        while (frames_done < target && n < 4000) begin
            @(posedge xclk);
            n++;
        end
        check("frames_seen", 32'(frames_done), 32'(target));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(posedge xclk); #1;
            n++;
        end
        check("bus_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_sync(input int ch);
        int n = 0;
        while (lsync[ch] !== 1'b1 && n < 400) begin
            @(posedge xclk); #1;
            n++;
        end
        check("sync_seen", 32'(lsync[ch]), 32'd1);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge xclk);
        @(negedge xclk);
        check("rst_sync", 32'(lsync), 32'h0);
        check("rst_clk", 32'(lclk), 32'd1);
        check("rst_data", 32'(ldata), 32'd0);
        check("rst_clr", 32'(lclr), 32'd1);
        check("rst_busy_init_all", 32'(busy), 32'd1);

        // INIT_ALL drain: 16 midscale frames in channel order, clr held 8 cycles
        expect_init_frames();
        @(posedge xclk); #1;
        reset = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge xclk);
            if (lclr) n++;
        end
        check("clr_hold_cycles", 32'(n), 32'd8);
        wait_frames();
        wait_idle();

        // Idle write latency: sync asserts 2 cycles after the write
        expect_frame(1, 16'h0F0C);
        wr(8'h41, 12'h3C3);
        wr_end();
        @(negedge xclk);
        check("lat_cycle1_sync", 32'(lsync), 32'h0);
        @(negedge xclk);
        check("lat_cycle2_sync", 32'(lsync), 32'h0002);
        wait_frames();
        wait_idle();

        // Round robin: while ch0 is in flight write ch5 then ch2; pointer after ch0 is 1
        expect_frame(0, 16'h0140);
        expect_frame(2, 16'h048C);
        expect_frame(5, 16'h2AF0);
        wr(8'h40, 12'h050);
        wr_end();
        wait_sync(0);
        wr(8'h45, 12'hABC);
        wr(8'h42, 12'h123);
        wr_end();
        wait_frames();
        wait_idle();

        // Rewrite of the in-flight channel: current frame intact, new value sent next
        expect_frame(3, 16'h0888);
        expect_frame(3, 16'h0444);
        wr(8'h43, 12'h222);
        wr_end();
        wait_sync(3);
        wr(8'h43, 12'h111);
        wr_end();
        wait_frames();
        wait_idle();

        // Wrong address nibble is ignored
        wr(8'h53, 12'hFFF);
        wr_end();
        repeat (3) @(posedge xclk);
        #1;
        check("bad_nib_ignored", 32'(busy), 32'd0);

        // Fairness: ch0 rewritten every cycle, ch7 still goes second
        expect_frame(0, 16'h02A8);
        expect_frame(7, 16'h1DDC);
        expect_frame(0, 16'h02A8);
        wr(8'h40, 12'h0AA);
        wr(8'h47, 12'h777);
        n = 0;
        while (lsync[7] !== 1'b1 && n < 600) begin
            wr(8'h40, 12'h0AA);
            n++;
        end
        check("fair_ch7_started", 32'(lsync[7]), 32'd1);
        wr_end();
        wait_frames();
        wait_idle();

`ifdef DAC_READBACK_EN
        // Readback of a written shadow value
        expect_frame(9, 16'h1694);
        wr(8'h49, 12'h5A5);
        wr_end();
        @(posedge xclk); #1;
        read_qualified = 1'b1;
        ab = 8'h49;
        @(posedge xclk); #1;
        read_qualified = 1'b0;
        check("rb_avail", 32'(data_avail), 32'd1);
        check("rb_data", 32'(db_out), 32'h5A5);
        @(posedge xclk); #1;
        check("rb_avail_pulse", 32'(data_avail), 32'd0);
        wait_frames();
        wait_idle();
`endif

        // Reset mid-frame at bit 9: pins drop in the reset cycle, shadows back to midscale
        wr(8'h43, 12'h333);
        wr_end();
        n = 0;
        while (!(in_frame && mon_bits >= 9) && n < 400) begin
            @(posedge xclk);
            n++;
        end
        check("abort_reached_bit9", 32'(mon_bits), 32'd9);
        #1;
        reset = 1'b1;
        @(negedge xclk);
        check("abort_sync", 32'(lsync), 32'h0);
        check("abort_clk", 32'(lclk), 32'd1);
        @(posedge xclk); #1;
        expect_init_frames();
        reset = 1'b0;
        wait_frames();
        wait_idle();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 2 ms");
        $fatal(1);
    end

endmodule
